// File: rtl/scope_pkg.sv
// Shared scope definitions: capture FSM encoding, ADC word layout and
// the trigger settings latched on arm.
package scope_pkg;

    localparam int unsigned SAMPLE_W = 32;
    localparam int unsigned CH_W     = 14;
    localparam int unsigned CH_A_MSB = 29;
    localparam int unsigned CH_A_LSB = 16;
    localparam int unsigned CH_B_MSB = 13;
    localparam int unsigned CH_B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    typedef logic signed [CH_W-1:0] chan_t;

    typedef struct packed {
        logic  continuous;
        logic  ch;
        logic  rising;
        chan_t level;
    } trig_cfg_t;

endpackage

// File: rtl/capture_controller_if.sv
// Sample-stream, FIFO-side and control bundle of the capture controller.
// The slave modport is the controller's view; master is the surrounding logic.
interface capture_controller_if #(
    parameter int unsigned LEN_W = 10
);
    import scope_pkg::*;

    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                fifo_full;
    logic                fifo_empty;
    logic                arm;
    logic                abort;
    logic                continuous;
    logic                trig_ch;
    logic                trig_rising;
    chan_t               trig_level;
    logic [LEN_W-1:0]    cap_len;
    logic [SAMPLE_W-1:0] fifo_din;
    logic                fifo_wr_en;
    logic                busy;
    logic                triggered;
    logic                overrun;

    modport master (
        output sample_in, sample_valid, fifo_full, fifo_empty, arm, abort,
               continuous, trig_ch, trig_rising, trig_level, cap_len,
        input  fifo_din, fifo_wr_en, busy, triggered, overrun
    );

    modport slave (
        input  sample_in, sample_valid, fifo_full, fifo_empty, arm, abort,
               continuous, trig_ch, trig_rising, trig_level, cap_len,
        output fifo_din, fifo_wr_en, busy, triggered, overrun
    );

endinterface

// File: rtl/trig_detect.sv
// Level-crossing detector: tracks the previous channel value while enabled
// and flags a crossing combinationally in the cycle of the qualifying sample.
module trig_detect
    import scope_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                ch,
    input  logic                rising,
    input  chan_t               level,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                valid,
    output logic                hit
);

    chan_t cur;
    chan_t prev;
    logic  primed;
    logic  unused_bits;

    assign cur = ch ? chan_t'(sample[CH_B_MSB:CH_B_LSB]) : chan_t'(sample[CH_A_MSB:CH_A_LSB]);
    assign unused_bits = ^{sample[SAMPLE_W-1:CH_A_MSB+1], sample[CH_A_LSB-1:CH_B_MSB+1]};

    // primed drops whenever disabled so the first sample after (re)arming only seeds prev
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev   <= '0;
            primed <= 1'b0;
        end else if (!en) begin
            primed <= 1'b0;
        end else if (valid) begin
            prev   <= cur;
            primed <= 1'b1;
        end
    end

    always_comb begin
        hit = 1'b0;
        if (en && valid && primed) begin
            if (rising) hit = (prev < level) && (level <= cur);
            else        hit = (prev > level) && (level >= cur);
        end
    end

endmodule

// File: rtl/capture_controller.sv
// Triggered capture sequencer between the ADC stream and the sample FIFO.
// Define CAPTURE_AUTO_TRIG_EN to force a trigger after TIMEOUT_SAMPLES armed samples.
module capture_controller
    import scope_pkg::*;
#(
    parameter int unsigned LEN_W           = 10,
    parameter int unsigned TIMEOUT_SAMPLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    capture_controller_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    trig_cfg_t        cfg;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       drain_wait;
    logic             hit;
    logic             trig_c;
    logic             arm_c;
    logic             take_c;
    logic             write_c;
    logic             drop_c;

    assign arm_c = bus.arm && (bus.cap_len != '0);

    trig_detect u_trig (
        .clk    (clk),
        .rst    (rst),
        .en     (state == ST_ARMED),
        .ch     (cfg.ch),
        .rising (cfg.rising),
        .level  (cfg.level),
        .sample (bus.sample_in),
        .valid  (bus.sample_valid),
        .hit    (hit)
    );

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            force_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     to_cnt <= '0;
        else if (state != ST_ARMED)  to_cnt <= '0;
        else if (bus.sample_valid)   to_cnt <= to_cnt + 1'b1;
    end

    assign force_c = (state == ST_ARMED) && bus.sample_valid &&
                     (to_cnt == TO_W'(TIMEOUT_SAMPLES - 1));
    assign trig_c  = hit | force_c;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_SAMPLES == 0);
    assign trig_c = hit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (arm_c) state_nxt = ST_ARMED;
                ST_ARMED:   if (trig_c) state_nxt = (len_q == LEN_W'(1)) ? ST_DRAIN : ST_CAPTURE;
                ST_CAPTURE: if (bus.sample_valid && (remaining == LEN_W'(1))) state_nxt = ST_DRAIN;
                ST_DRAIN:   if ((drain_wait == 2'd0) && bus.fifo_empty)
                                state_nxt = cfg.continuous ? ST_ARMED : ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // A sample inside the capture window counts even when fifo_full drops it
    always_comb begin
        take_c = 1'b0;
        if (!bus.abort) begin
            case (state)
                ST_ARMED:   take_c = trig_c;
                ST_CAPTURE: take_c = bus.sample_valid;
                default:    take_c = 1'b0;
            endcase
        end
        write_c = take_c && !bus.fifo_full;
        drop_c  = take_c && bus.fifo_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fifo_din   <= '0;
            bus.fifo_wr_en <= 1'b0;
            bus.busy       <= 1'b0;
            bus.triggered  <= 1'b0;
            bus.overrun    <= 1'b0;
            cfg            <= '0;
            len_q          <= '0;
            remaining      <= '0;
            drain_wait     <= '0;
        end else begin
            bus.fifo_wr_en <= write_c;
            if (write_c) bus.fifo_din <= bus.sample_in;
            bus.busy      <= (state != ST_IDLE);
            bus.triggered <= (state == ST_CAPTURE) || (state == ST_DRAIN);

            if ((state == ST_IDLE) && arm_c && !bus.abort) begin
                len_q       <= bus.cap_len;
                cfg         <= '{continuous: bus.continuous, ch: bus.trig_ch,
                                 rising: bus.trig_rising, level: bus.trig_level};
                bus.overrun <= 1'b0;
            end else if (drop_c) begin
                bus.overrun <= 1'b1;
            end

            if (take_c) remaining <= (state == ST_ARMED) ? len_q - LEN_W'(1) : remaining - LEN_W'(1);

            // hold off the empty check until the final write has reached the FIFO flags
            if ((state_nxt == ST_DRAIN) && (state != ST_DRAIN)) drain_wait <= 2'd2;
            else if (drain_wait != 2'd0)                        drain_wait <= drain_wait - 2'd1;
        end
    end

endmodule

// File: doc/capture_controller.md
# capture_controller

Trigger and capture sequencer placed between `adc_controller` and the sample FIFO in the scope top level. It watches the 32-bit ADC sample stream and waits for an armed level-crossing trigger on a selected channel. It then gates exactly `cap_len` samples into the FIFO and holds off re-arming until the UART path has drained the FIFO. This makes each UART burst one coherent, triggered acquisition instead of a free-running stream.

## Interface
Parameters:
- `LEN_W`, 10: width of the capture-length counter; max capture is 2^LEN_W−1 samples.
- `TIMEOUT_SAMPLES`, 65535: valid samples spent in ARMED before an auto trigger (only with `CAPTURE_AUTO_TRIG_EN`).

Ports:
- `clk` in 1: system clock; all logic runs on this single clock.
- `rst` in 1: asynchronous, active-high reset.
- `sample_in` in 32: ADC word; channel A is `[29:16]` and channel B is `[13:0]`, both 14-bit two's complement.
- `sample_valid` in 1: one-cycle strobe marking a new `sample_in` (the `adc_controller` wr_en).
- `fifo_full` in 1: FIFO full flag.
- `fifo_empty` in 1: FIFO empty flag.
- `arm` in 1: one-cycle start request.
- `abort` in 1: one-cycle return to IDLE.
- `continuous` in 1: 1 = re-arm automatically after drain; 0 = single shot.
- `trig_ch` in 1: trigger channel, 0 = A, 1 = B.
- `trig_rising` in 1: 1 = rising-edge trigger, 0 = falling-edge trigger.
- `trig_level` in 14: signed trigger threshold.
- `cap_len` in LEN_W: samples per capture; sampled on arm.
- `fifo_din` out 32: registered sample to FIFO.
- `fifo_wr_en` out 1: FIFO write strobe.
- `busy` out 1: state ≠ IDLE.
- `triggered` out 1: state is CAPTURE or DRAIN.
- `overrun` out 1: sticky; at least one capture sample was dropped on `fifo_full`.

## Operation
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE: on `arm`, if `cap_len` ≠ 0, latch `cap_len` and the trigger settings, clear `overrun`, and go to ARMED. If `cap_len` = 0, ignore `arm`.
- `arm` is ignored in every state except IDLE.
- ARMED: the previous channel value `prev` is updated on every `sample_valid`. The first valid sample after entering ARMED only loads `prev`. All comparisons are signed.
  - Rising trigger: `prev` < `trig_level` ≤ `cur`.
  - Falling trigger: `prev` > `trig_level` ≥ `cur`.
  - On a trigger, write the trigger sample, set `remaining` = latched length − 1, and go to CAPTURE. If length = 1, go directly to DRAIN.
- CAPTURE: write each valid sample and decrement `remaining`. On the write that brings `remaining` to 0, go to DRAIN.
- `fifo_full` handling, in ARMED (trigger sample) and CAPTURE:
  - A valid sample that arrives while `fifo_full` is high is not written, and `overrun` is set.
  - It still counts toward `remaining`, so the capture window stays fixed in time.
- DRAIN: wait for `fifo_empty` = 1, sampled no earlier than 2 cycles after the last write. Then go to ARMED if the latched `continuous` is 1, otherwise to IDLE.
- `abort` in any state goes to IDLE on the next edge. `abort` has priority over a simultaneous `arm` or trigger. A write requested in the abort cycle is suppressed.
- No writes occur in IDLE or DRAIN. Samples arriving there are discarded.

## Timing
- Reset values: state IDLE; `fifo_din` 0; `fifo_wr_en`, `busy`, `triggered`, `overrun` all 0; `prev` 0.
- Write latency: `fifo_wr_en` and `fifo_din` are asserted the cycle after the qualifying `sample_valid`. `fifo_wr_en` is a single-cycle pulse.
- State change: happens on the same edge as the corresponding write. `busy` and `triggered` are registered and reflect the new state one cycle after that edge.
- Reset mid-capture: the FIFO is not flushed by this block. The top level resets both together.

## Configuration
- `CAPTURE_AUTO_TRIG_EN` defined:
  - In ARMED, a counter of valid samples forces a trigger when it reaches `TIMEOUT_SAMPLES` without a level crossing. This is scope "auto" mode.
  - The counter clears on entry to ARMED.
  - A forced trigger behaves exactly like a real one, including writing the current sample.
- Undefined: no counter is built, and ARMED waits indefinitely (normal mode).

## Structure
- Shared package `scope_pkg`:
  - state encoding;
  - channel bit-field constants (`CH_A_MSB`=29, `CH_A_LSB`=16, `CH_B_MSB`=13, `CH_B_LSB`=0);
  - sample width 32 and channel width 14.
- One sub-module, `trig_detect`: registers `prev` and produces a one-cycle `hit`. It takes channel select, edge, level, the sample and valid as inputs.

## Test plan
- Single shot, rising edge, ch A, level 100, `cap_len` 8:
  - stimulus ramp −50, 0, 50, 150, …;
  - expect exactly 8 writes starting with the 150 sample;
  - expect `busy` to drop after the FIFO empties.
- Falling edge, ch B, level 0, `continuous` 1, `cap_len` 4:
  - expect two consecutive 4-sample bursts;
  - the second burst must trigger only on a new crossing after drain.
- `fifo_full` forced high for 2 samples mid-capture, `cap_len` 10: expect 8 writes, `overrun` = 1, and capture ending on schedule.
- `abort` in the same cycle as a trigger crossing: expect no write, state IDLE, `busy` 0 two cycles later.
- `arm` with `cap_len` 0, and `arm` pulsed again during CAPTURE: both ignored, with no change in state or count.
- With `CAPTURE_AUTO_TRIG_EN`, `TIMEOUT_SAMPLES` = 16, constant input (no crossing):
  - expect a forced trigger on the 16th valid sample followed by `cap_len` writes;
  - without the macro, expect zero writes after 100 samples.
